// File: rtl/ring_bank_bram.sv
// Banked ring buffer in block RAM: a writer fills equal-size banks in order, a reader
// releases them; full banks either stall the writer or are overwritten with a sticky flag.
module ring_bank_bram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 16384,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned OVERWRITE    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/8-1:0]      wr_be,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  input  logic                         rel_valid,
  input  logic [$clog2(NUM_BANKS)-1:0] rel_bank,
  output logic [NUM_BANKS-1:0]         bank_full,
  output logic                         bank_done,
  output logic [$clog2(NUM_BANKS)-1:0] bank_done_idx,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned WordAw   = $clog2(DEPTH);
  localparam int unsigned BankAw   = $clog2(NUM_BANKS);
  localparam int unsigned OffAw    = WordAw - BankAw;
  localparam int unsigned ByteAw   = $clog2(NumBytes);

  logic [WordAw-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_BANKS-1:0]  bank_full_q, bank_full_d;
  logic                  bank_done_q, bank_done_d;
  logic [BankAw-1:0]     done_idx_q, done_idx_d;
  logic                  overflow_q, overflow_d;
  logic                  ovf_set;

  logic [BankAw-1:0]     cur_bank;
  logic [OffAw-1:0]      cur_off;
  logic                  cur_full;
  logic                  at_first, at_last;
  logic                  wr_fire;

  assign cur_bank = wr_ptr_q[WordAw-1:OffAw];
  assign cur_off  = wr_ptr_q[OffAw-1:0];
  assign cur_full = bank_full_q[cur_bank];
  assign at_first = (cur_off == '0);
  assign at_last  = &cur_off;

  assign wr_ready = (OVERWRITE != 0) ? 1'b1 : !cur_full;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    bank_full_d = bank_full_q;
    bank_done_d = 1'b0;
    done_idx_d  = done_idx_q;
    ovf_set     = 1'b0;
    if (rel_valid) begin
      bank_full_d[rel_bank] = 1'b0;
    end
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + WordAw'(1);
      // Only reachable in overwrite mode: re-entering a full bank discards its contents.
      if ((OVERWRITE != 0) && at_first && cur_full) begin
        bank_full_d[cur_bank] = 1'b0;
        ovf_set               = 1'b1;
      end
      // Assigned after the release so a same-cycle fill wins.
      if (at_last) begin
        bank_full_d[cur_bank] = 1'b1;
        bank_done_d           = 1'b1;
        done_idx_d            = cur_bank;
      end
    end
    overflow_d = ovf_set | (overflow_q & ~clr_overflow);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      bank_full_q <= '0;
      bank_done_q <= 1'b0;
      done_idx_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      bank_full_q <= bank_full_d;
      bank_done_q <= bank_done_d;
      done_idx_q  <= done_idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_ptr        = wr_ptr_q;
  assign bank_full     = bank_full_q;
  assign bank_done     = bank_done_q;
  assign bank_done_idx = done_idx_q;
  assign overflow      = overflow_q;

  // Storage: no reset so it maps onto block RAM; read-first via non-blocking update.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;
  logic [WordAw-1:0]     rd_word;
  logic                  unused_rd_addr;

  assign rd_word        = rd_addr[ByteAw +: WordAw];
  assign unused_rd_addr = ^rd_addr;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wr_be[b]) begin
          mem[wr_ptr_q][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      mem_rd_q <= mem[rd_word];
    end
  end

  logic rd_v1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_q <= 1'b0;
    end else begin
      rd_v1_q <= rd_en;
    end
  end

  if (READ_LATENCY == 1) begin : gen_rl1
    // RAM output register has no reset; mask it until a post-reset read has landed.
    logic seen_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        seen_q <= 1'b0;
      end else begin
        seen_q <= seen_q | rd_en;
      end
    end

    assign rd_data  = seen_q ? mem_rd_q : '0;
    assign rd_valid = rd_v1_q;
  end else begin : gen_rl2
    logic                  rd_v2_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_v2_q   <= 1'b0;
        rd_data_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          rd_data_q <= mem_rd_q;
        end
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_v2_q;
  end

endmodule

// File: tb/tb_ring_bank_bram.sv
// Directed bench: dut0 stalls on full banks with one-cycle reads, dut1 overwrites with
// two-cycle reads. Shared stimulus is steered to one instance by sel.
module tb_ring_bank_bram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        wr_valid, rd_en, rel_valid, clr_overflow;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [5:0]  rd_addr;
  logic [0:0]  rel_bank;

  logic        wr_ready0, wr_ready1, rd_valid0, rd_valid1, bank_done0, bank_done1;
  logic        overflow0, overflow1;
  logic [31:0] rd_data0, rd_data1;
  logic [1:0]  bank_full0, bank_full1;
  logic [0:0]  done_idx0, done_idx1;
  logic [3:0]  wr_ptr0, wr_ptr1;

  logic        wr_ready_m, rd_valid_m, bank_done_m, overflow_m;
  logic [31:0] rd_data_m;
  logic [1:0]  bank_full_m;
  logic [0:0]  done_idx_m;
  logic [3:0]  wr_ptr_m;

  assign wr_ready_m  = sel ? wr_ready1  : wr_ready0;
  assign rd_valid_m  = sel ? rd_valid1  : rd_valid0;
  assign bank_done_m = sel ? bank_done1 : bank_done0;
  assign overflow_m  = sel ? overflow1  : overflow0;
  assign rd_data_m   = sel ? rd_data1   : rd_data0;
  assign bank_full_m = sel ? bank_full1 : bank_full0;
  assign done_idx_m  = sel ? done_idx1  : done_idx0;
  assign wr_ptr_m    = sel ? wr_ptr1    : wr_ptr0;

  ring_bank_bram #(
    .DATA_WIDTH(32), .DEPTH(16), .NUM_BANKS(2), .ADDR_WIDTH(6),
    .READ_LATENCY(1), .OVERWRITE(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid & ~sel), .wr_ready(wr_ready0), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en & ~sel), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .rel_valid(rel_valid & ~sel), .rel_bank(rel_bank), .bank_full(bank_full0),
    .bank_done(bank_done0), .bank_done_idx(done_idx0), .wr_ptr(wr_ptr0),
    .overflow(overflow0), .clr_overflow(clr_overflow & ~sel)
  );

  ring_bank_bram #(
    .DATA_WIDTH(32), .DEPTH(16), .NUM_BANKS(2), .ADDR_WIDTH(6),
    .READ_LATENCY(2), .OVERWRITE(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid & sel), .wr_ready(wr_ready1), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en & sel), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .rel_valid(rel_valid & sel), .rel_bank(rel_bank), .bank_full(bank_full1),
    .bank_done(bank_done1), .bank_done_idx(done_idx1), .wr_ptr(wr_ptr1),
    .overflow(overflow1), .clr_overflow(clr_overflow & sel)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_be    = be;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp,
                    input int lat);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check($sformatf("%s_early", tag), rd_valid_m, 0);
      tick();
    end
    check($sformatf("%s_vld", tag), rd_valid_m, 1);
    check(tag, rd_data_m, exp);
  endtask

  task automatic release_bank(input logic [0:0] b);
    rel_valid = 1'b1;
    rel_bank  = b;
    tick();
    rel_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    sel = 1'b0; rst = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0; rd_en = 1'b0; rd_addr = '0;
    rel_valid = 1'b0; rel_bank = '0; clr_overflow = 1'b0;
    tick();
    tick();
    check("rst_wr_ptr", wr_ptr_m, 0);
    check("rst_full", bank_full_m, 0);
    check("rst_done", bank_done_m, 0);
    check("rst_ovf", overflow_m, 0);
    check("rst_rd_valid", rd_valid_m, 0);
    check("rst_rd_data", rd_data_m, 0);
    check("rst_ready", wr_ready_m, 1);
    rst = 1'b1;
    tick();

    // ---- dut0: stall mode, read latency 1 ----
    for (int i = 0; i < 8; i++) wr(32'hA0 + i, 4'hF);
    check("b0_done", bank_done_m, 1);
    check("b0_idx", done_idx_m, 0);
    check("b0_full", bank_full_m, 2'b01);
    check("b0_ptr", wr_ptr_m, 8);
    tick();
    check("b0_done_pulse", bank_done_m, 0);
    for (int i = 0; i < 8; i++) rd("rd_a", 6'(i * 4), 32'hA0 + i, 1);
    tick();
    check("hold_vld", rd_valid_m, 0);
    check("hold_data", rd_data_m, 32'hA7);

    for (int i = 8; i < 16; i++) wr(32'h100 + i, 4'hF);
    check("b1_done", bank_done_m, 1);
    check("b1_idx", done_idx_m, 1);
    check("both_full", bank_full_m, 2'b11);
    check("wrap_ptr", wr_ptr_m, 0);
    check("stall_ready", wr_ready_m, 0);
    wr(32'hDEAD, 4'hF);
    check("stall_ptr", wr_ptr_m, 0);
    rd("stall_nowrite", 6'h00, 32'hA0, 1);

    release_bank(1'b0);
    check("rel_full", bank_full_m, 2'b10);
    check("rel_ready", wr_ready_m, 1);
    release_bank(1'b0);
    check("rel_nonfull", bank_full_m, 2'b10);

    for (int i = 0; i < 8; i++) begin
      v = (i == 3) ? 32'h11223344 : (i == 5) ? 32'h1 : 32'hB0 + i;
      if (i == 7) begin
        rel_valid = 1'b1;
        rel_bank  = 1'b0;
      end
      wr(v, 4'hF);
      rel_valid = 1'b0;
    end
    check("fill_wins", bank_full_m, 2'b11);
    check("refill_idx", done_idx_m, 0);

    // Reset lands on an accepted-but-unreturned read.
    rd_en = 1'b1; rd_addr = 6'h08;
    #2;
    rst = 1'b0;
    tick();
    rd_en = 1'b0;
    check("mid_rst_vld", rd_valid_m, 0);
    check("mid_rst_data", rd_data_m, 0);
    check("mid_rst_ptr", wr_ptr_m, 0);
    check("mid_rst_full", bank_full_m, 0);
    rst = 1'b1;
    tick();
    check("post_rst_vld", rd_valid_m, 0);
    rd("retained", 6'h08, 32'hB2, 1);

    for (int i = 0; i < 3; i++) wr(32'hFFFF_FFFF, 4'h0);
    check("be0_ptr", wr_ptr_m, 3);
    rd("be0_data", 6'h00, 32'hB0, 1);
    wr(32'hAABBCCDD, 4'h5);
    rd("byte_en", 6'h0C, 32'h11BB33DD, 1);
    wr(32'h44, 4'hF);
    wr_valid = 1'b1; wr_data = 32'h2; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 6'h14;
    tick();
    wr_valid = 1'b0; rd_en = 1'b0;
    check("rf_vld", rd_valid_m, 1);
    check("read_first", rd_data_m, 32'h1);
    rd("after_rf", 6'h14, 32'h2, 1);

    // ---- dut1: overwrite mode, read latency 2 ----
    sel = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) wr(32'hC0 + i, 4'hF);
    check("ow_full", bank_full_m, 2'b11);
    check("ow_ready", wr_ready_m, 1);
    check("ow_no_ovf", overflow_m, 0);
    wr(32'hD0, 4'hF);
    check("ow_17_full", bank_full_m, 2'b10);
    check("ow_17_ovf", overflow_m, 1);
    check("ow_17_ptr", wr_ptr_m, 1);
    tick();
    check("ovf_sticky", overflow_m, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", overflow_m, 0);

    rd("rl2_w0", 6'h00, 32'hD0, 2);
    rd("rl2_w5", 6'h14, 32'hC5, 2);
    rd_en = 1'b1; rd_addr = 6'h04;
    tick();
    rd_addr = 6'h08;
    tick();
    rd_en = 1'b0;
    check("pipe_vld0", rd_valid_m, 1);
    check("pipe_d0", rd_data_m, 32'hC1);
    tick();
    check("pipe_vld1", rd_valid_m, 1);
    check("pipe_d1", rd_data_m, 32'hC2);
    tick();
    check("pipe_idle", rd_valid_m, 0);
    check("pipe_hold", rd_data_m, 32'hC2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
